// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if
//   Bundles the pixel-source and VGA-connector signals of vga_timing_gen.
//   master : the timing generator (drives counts, strobes, syncs, RGB; reads *_in)
//   slave  : the pixel source / connector side
//   Signals:
//     red_in/green_in/blue_in   colour for the current (h_count, v_count)
//     pattern_sel               colour-bar select (only with VGA_TEST_PATTERN_EN)
//     h_count/v_count           raster position
//     pix_ce, video_active, frame_start
//     horizonal_sync/vertical_sync, red/green/blue   registered VGA outputs
interface vga_timing_gen_if #(
  parameter int COUNTER_BITS = 10,
  parameter int BIT_DEPTH    = 4
);
  logic [BIT_DEPTH-1:0]    red_in;
  logic [BIT_DEPTH-1:0]    green_in;
  logic [BIT_DEPTH-1:0]    blue_in;
`ifdef VGA_TEST_PATTERN_EN
  logic                    pattern_sel;
`endif
  logic [COUNTER_BITS-1:0] h_count;
  logic [COUNTER_BITS-1:0] v_count;
  logic                    pix_ce;
  logic                    video_active;
  logic                    frame_start;
  logic                    horizonal_sync;
  logic                    vertical_sync;
  logic [BIT_DEPTH-1:0]    red;
  logic [BIT_DEPTH-1:0]    green;
  logic [BIT_DEPTH-1:0]    blue;

  modport master (
    input  red_in, green_in, blue_in,
`ifdef VGA_TEST_PATTERN_EN
    input  pattern_sel,
`endif
    output h_count, v_count, pix_ce, video_active, frame_start,
    output horizonal_sync, vertical_sync, red, green, blue
  );

  modport slave (
    output red_in, green_in, blue_in,
`ifdef VGA_TEST_PATTERN_EN
    output pattern_sel,
`endif
    input  h_count, v_count, pix_ce, video_active, frame_start,
    input  horizonal_sync, vertical_sync, red, green, blue
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA raster timing generator with registered sync/RGB stage.
//   A clock divider produces pix_ce; h/v counters advance on it. Syncs and
//   blanked RGB are registered on pix_ce from the pre-increment counts, so they
//   lag the counts by exactly one pixel period.
//   Ports:
//     clk    system clock
//     reset  synchronous, active-high
//     vga    vga_timing_gen_if.master (pixel inputs, counts, strobes, VGA outputs)
//   Optional feature: define VGA_TEST_PATTERN_EN to add pattern_sel, which
//   replaces active-video RGB with 8 vertical colour bars.
module vga_timing_gen #(
  parameter int COUNTER_BITS = 10,
  parameter int BIT_DEPTH    = 4,
  parameter int CLK_DIV      = 4,
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter bit HS_POL       = 1'b0,
  parameter bit VS_POL       = 1'b0
) (
  input logic              clk,
  input logic              reset,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
  localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [COUNTER_BITS-1:0] H_LAST   = COUNTER_BITS'(H_TOTAL - 1);
  localparam logic [COUNTER_BITS-1:0] V_LAST   = COUNTER_BITS'(V_TOTAL - 1);
  localparam logic [COUNTER_BITS-1:0] H_ACT_C  = COUNTER_BITS'(H_ACTIVE);
  localparam logic [COUNTER_BITS-1:0] V_ACT_C  = COUNTER_BITS'(V_ACTIVE);
  localparam logic [COUNTER_BITS-1:0] HS_START = COUNTER_BITS'(H_ACTIVE + H_FP);
  localparam logic [COUNTER_BITS-1:0] HS_END   = COUNTER_BITS'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COUNTER_BITS-1:0] VS_START = COUNTER_BITS'(V_ACTIVE + V_FP);
  localparam logic [COUNTER_BITS-1:0] VS_END   = COUNTER_BITS'(V_ACTIVE + V_FP + V_SYNC);

  if (CLK_DIV < 1 || (64'd1 << COUNTER_BITS) <= 64'(MAX_TOTAL - 1)) begin : g_bad_cfg
    $error("vga_timing_gen: CLK_DIV must be >= 1 and COUNTER_BITS must hold max(H_TOTAL,V_TOTAL)-1");
  end

  logic [DIV_W-1:0]        div_q, div_d;
  logic                    pix_ce_q, pix_ce_d;
  logic [COUNTER_BITS-1:0] h_q, h_d, v_q, v_d;
  logic                    hs_q, hs_d, vs_q, vs_d;
  logic [BIT_DEPTH-1:0]    r_q, r_d, g_q, g_d, b_q, b_d;
  logic                    active;
  logic [BIT_DEPTH-1:0]    src_r, src_g, src_b;

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [COUNTER_BITS-1:0] BAR_W = COUNTER_BITS'(H_ACTIVE / 8);
  logic [2:0] bar;
`endif

  always_comb begin
    active = (h_q < H_ACT_C) && (v_q < V_ACT_C);

`ifdef VGA_TEST_PATTERN_EN
    bar = 3'(h_q / BAR_W);
    if (vga.pattern_sel) begin
      src_r = {BIT_DEPTH{bar[2]}};
      src_g = {BIT_DEPTH{bar[1]}};
      src_b = {BIT_DEPTH{bar[0]}};
    end else begin
      src_r = vga.red_in;
      src_g = vga.green_in;
      src_b = vga.blue_in;
    end
`else
    src_r = vga.red_in;
    src_g = vga.green_in;
    src_b = vga.blue_in;
`endif

    // pix_ce is registered from the divider terminal count, so it first
    // rises CLK_DIV clocks after reset and stays high when CLK_DIV == 1.
    pix_ce_d = (div_q == DIV_LAST);
    div_d    = pix_ce_d ? '0 : div_q + DIV_W'(1);

    h_d  = h_q;
    v_d  = v_q;
    hs_d = hs_q;
    vs_d = vs_q;
    r_d  = r_q;
    g_d  = g_q;
    b_d  = b_q;
    if (pix_ce_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + COUNTER_BITS'(1);
      end else begin
        h_d = h_q + COUNTER_BITS'(1);
      end
      hs_d = ((h_q >= HS_START) && (h_q < HS_END)) ? HS_POL : ~HS_POL;
      vs_d = ((v_q >= VS_START) && (v_q < VS_END)) ? VS_POL : ~VS_POL;
      r_d  = active ? src_r : '0;
      g_d  = active ? src_g : '0;
      b_d  = active ? src_b : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q    <= '0;
      pix_ce_q <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
      hs_q     <= ~HS_POL;
      vs_q     <= ~VS_POL;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
    end else begin
      div_q    <= div_d;
      pix_ce_q <= pix_ce_d;
      h_q      <= h_d;
      v_q      <= v_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
    end
  end

  assign vga.h_count        = h_q;
  assign vga.v_count        = v_q;
  assign vga.pix_ce         = pix_ce_q;
  assign vga.video_active   = active;
  assign vga.frame_start    = pix_ce_q && (h_q == '0) && (v_q == '0);
  assign vga.horizonal_sync = hs_q;
  assign vga.vertical_sync  = vs_q;
  assign vga.red            = r_q;
  assign vga.green          = g_q;
  assign vga.blue           = b_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  vga_timing_gen_if #(.COUNTER_BITS(10), .BIT_DEPTH(4)) if_def ();
  vga_timing_gen_if #(.COUNTER_BITS(10), .BIT_DEPTH(4)) if_fast ();
  vga_timing_gen_if #(.COUNTER_BITS(10), .BIT_DEPTH(4)) if_small ();

  vga_timing_gen u_def (.clk(clk), .reset(reset), .vga(if_def.master));

  vga_timing_gen #(.CLK_DIV(1), .HS_POL(1'b1)) u_fast (
    .clk(clk), .reset(reset), .vga(if_fast.master));

  // Small mode: H_TOTAL 24 (hsync 18..21), V_TOTAL 12 (vsync 9..10), 576 clks/frame
  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_small (.clk(clk), .reset(reset), .vga(if_small.master));

  typedef struct {
    int n; int h; int v; int pix; int fs; int va; int hs; int vs; int rgb;
  } vec_t;
  localparam int NV = 14;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic step_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  function automatic logic [31:0] rgb_of(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    return {20'd0, r, g, b};
  endfunction

  int  fs_cnt, vs_lo, hs_lo, rgb_nz, max_h, max_v;
  int  f_pix_bad, f_hs_hi, f_hs_first, f_hs_last;
  bit  found;

  initial begin
    //           n     h    v  pix fs va hs vs rgb
    vecs[0]  = '{0,    0,   0, 0, 0, 1, 1, 1, 'h000};
    vecs[1]  = '{1,    0,   0, 0, 0, 1, 1, 1, 'h000};
    vecs[2]  = '{4,    0,   0, 1, 1, 1, 1, 1, 'h000};
    vecs[3]  = '{5,    1,   0, 0, 0, 1, 1, 1, 'hFFF};
    vecs[4]  = '{2560, 639, 0, 1, 0, 1, 1, 1, 'hFFF};
    vecs[5]  = '{2561, 640, 0, 0, 0, 0, 1, 1, 'hFFF};
    vecs[6]  = '{2565, 641, 0, 0, 0, 0, 1, 1, 'h000};
    vecs[7]  = '{2628, 656, 0, 1, 0, 0, 1, 1, 'h000};
    vecs[8]  = '{2629, 657, 0, 0, 0, 0, 0, 1, 'h000};
    vecs[9]  = '{3009, 752, 0, 0, 0, 0, 0, 1, 'h000};
    vecs[10] = '{3013, 753, 0, 0, 0, 0, 1, 1, 'h000};
    vecs[11] = '{3200, 799, 0, 1, 0, 0, 1, 1, 'h000};
    vecs[12] = '{3201, 0,   1, 0, 0, 1, 1, 1, 'h000};
    vecs[13] = '{3205, 1,   1, 0, 0, 1, 1, 1, 'hFFF};

    if_def.red_in = 4'hF;   if_def.green_in = 4'hF;   if_def.blue_in = 4'hF;
    if_fast.red_in = 4'h0;  if_fast.green_in = 4'h0;  if_fast.blue_in = 4'h0;
    if_small.red_in = 4'hF; if_small.green_in = 4'hF; if_small.blue_in = 4'hF;
`ifdef VGA_TEST_PATTERN_EN
    if_def.pattern_sel = 1'b0; if_fast.pattern_sel = 1'b0; if_small.pattern_sel = 1'b0;
`endif

    // Default mode: table of hand-computed samples, N clocks after reset release
    do_reset(3);
    for (int i = 0; i < NV; i++) begin
      step_to(vecs[i].n);
      chk($sformatf("v%0d.h", i),   if_def.h_count,        vecs[i].h);
      chk($sformatf("v%0d.v", i),   if_def.v_count,        vecs[i].v);
      chk($sformatf("v%0d.pix", i), if_def.pix_ce,         vecs[i].pix);
      chk($sformatf("v%0d.fs", i),  if_def.frame_start,    vecs[i].fs);
      chk($sformatf("v%0d.va", i),  if_def.video_active,   vecs[i].va);
      chk($sformatf("v%0d.hs", i),  if_def.horizonal_sync, vecs[i].hs);
      chk($sformatf("v%0d.vs", i),  if_def.vertical_sync,  vecs[i].vs);
      chk($sformatf("v%0d.rgb", i), rgb_of(if_def.red, if_def.green, if_def.blue), vecs[i].rgb);
    end

    // Small-mode frame statistics and CLK_DIV=1 / HS_POL=1 line statistics
    do_reset(3);
    fs_cnt = 0; vs_lo = 0; hs_lo = 0; rgb_nz = 0; max_h = 0; max_v = 0;
    f_pix_bad = 0; f_hs_hi = 0; f_hs_first = -1; f_hs_last = -1;
    for (int n = 1; n <= 1200; n++) begin
      step_to(n);
      if (if_small.frame_start) fs_cnt++;
      if (!if_small.vertical_sync) vs_lo++;
      if (!if_small.horizonal_sync) hs_lo++;
      if (rgb_of(if_small.red, if_small.green, if_small.blue) != 0) rgb_nz++;
      if (int'(if_small.h_count) > max_h) max_h = int'(if_small.h_count);
      if (int'(if_small.v_count) > max_v) max_v = int'(if_small.v_count);
      if (if_fast.pix_ce !== 1'b1) f_pix_bad++;
      if (if_fast.horizonal_sync) begin
        f_hs_hi++;
        if (f_hs_first < 0) f_hs_first = n;
        f_hs_last = n;
      end
    end
    chk("small.frame_starts", fs_cnt, 3);
    chk("small.vsync_low_clks", vs_lo, 192);
    chk("small.hsync_low_clks", hs_lo, 200);
    chk("small.rgb_active_clks", rgb_nz, 544);
    chk("small.max_h", max_h, 23);
    chk("small.max_v", max_v, 11);
    chk("fast.pix_ce_low_clks", f_pix_bad, 0);
    chk("fast.hsync_high_clks", f_hs_hi, 96);
    chk("fast.hsync_first", f_hs_first, 658);
    chk("fast.hsync_last", f_hs_last, 753);

    // Mid-frame reset on the small mode at (h=20, v=9): inside both sync windows
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      step_to(cyc + 1);
      if (if_small.h_count == 10'd20 && if_small.v_count == 10'd9) found = 1'b1;
    end
    chk("midreset.reached", found, 1);
    if (found) begin
      chk("midreset.pre_hs", if_small.horizonal_sync, 0);
      chk("midreset.pre_vs", if_small.vertical_sync, 0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("midreset.h", if_small.h_count, 0);
      chk("midreset.v", if_small.v_count, 0);
      chk("midreset.hs", if_small.horizonal_sync, 1);
      chk("midreset.vs", if_small.vertical_sync, 1);
      chk("midreset.rgb", rgb_of(if_small.red, if_small.green, if_small.blue), 0);
      chk("midreset.pix", if_small.pix_ce, 0);
    end

`ifdef VGA_TEST_PATTERN_EN
    // Colour bars: bar width 80; output lags counts by one pixel
    if_def.red_in = 4'h5; if_def.green_in = 4'h5; if_def.blue_in = 4'h5;
    if_def.pattern_sel = 1'b1;
    do_reset(3);
    step_to(5);
    chk("pat.h0", rgb_of(if_def.red, if_def.green, if_def.blue), 'h000);
    step_to(325);
    chk("pat.h80", rgb_of(if_def.red, if_def.green, if_def.blue), 'h00F);
    step_to(2245);
    chk("pat.h560", rgb_of(if_def.red, if_def.green, if_def.blue), 'hFFF);
    step_to(2565);
    chk("pat.h640", rgb_of(if_def.red, if_def.green, if_def.blue), 'h000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
